// File: rtl/cursor_position_pkg.sv
// Shared types for the canvas cursor: FSM states and the signed per-axis direction.
package cursor_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} cursor_state_t;

  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } dir_t;

  localparam dir_t DIR_IDLE = '{dx: 2'b00, dy: 2'b00};

  // Two's complement difference of a button pair: +1, -1, or 0 when both or neither are held.
  function automatic logic [1:0] dirOf(input logic pos, input logic neg);
    return (pos && !neg) ? 2'b01 : ((neg && !pos) ? 2'b11 : 2'b00);
  endfunction

endpackage

// File: rtl/cursor_position_if.sv
// Button/load inputs and cursor outputs between input conditioning and the canvas.
interface cursor_position_if #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 32
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  logic          left, right, up, down;
  logic          wrap_en;
  logic          load;
  logic [XW-1:0] load_x;
  logic [YW-1:0] load_y;
  logic [XW-1:0] userX;
  logic [YW-1:0] userY;
  logic          moved;

  modport master (output left, right, up, down, wrap_en, load, load_x, load_y,
                  input  userX, userY, moved);
  modport slave  (input  left, right, up, down, wrap_en, load, load_x, load_y,
                  output userX, userY, moved);
endinterface

// File: rtl/cursor_position_axis.sv
// One grid axis: applies a -1/0/+1 step with wrap or clamp at 0 and N-1.
module axis_stepper #(
  parameter int N = 64
) (
  input  logic [$clog2(N)-1:0] pos,
  input  logic [1:0]           d,
  input  logic                 wrap_en,
  output logic [$clog2(N)-1:0] next_pos,
  output logic                 changed
);
  localparam int W = $clog2(N);
  localparam logic [W:0]   MAX_EXT = (W+1)'(N - 1);
  localparam logic [W-1:0] MAX_POS = W'(N - 1);

  logic [W:0] inc;

  // Increment one bit wide so the overflow past N-1 is visible even when N is a power of two.
  always_comb begin
    next_pos = pos;
    inc      = {1'b0, pos} + 1'b1;
    case (d)
      2'b01:   next_pos = (inc > MAX_EXT) ? (wrap_en ? '0 : pos) : inc[W-1:0];
      2'b11:   next_pos = (pos == '0) ? (wrap_en ? MAX_POS : pos) : pos - 1'b1;
      default: next_pos = pos;
    endcase
  end

  assign changed = (next_pos != pos);

endmodule

// File: rtl/cursor_position.sv
// Cursor register: button levels -> (x, y) with hold-to-repeat, wrap/clamp and direct load.
import cursor_pkg::*;

module cursor_position #(
  parameter int GRID_W       = 64,
  parameter int GRID_H       = 32,
  parameter int X_INIT       = 0,
  parameter int Y_INIT       = 0,
  parameter int REPEAT_DELAY = 1,
  parameter int REPEAT_RATE  = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  cursor_position_if.slave  bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1;
  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
  localparam logic [CW-1:0] CNT_DLY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] CNT_RATE = CW'(REPEAT_RATE);

  cursor_state_t curState, nextState;
  logic [CW-1:0] cnt, nextCnt;
  dir_t          curD, latD, nextLatD;
  logic          step;
  logic [XW-1:0] posX, stepX, loadX;
  logic [YW-1:0] posY, stepY, loadY;
  logic          xChanged, yChanged, movedQ;

  assign curD.dx = dirOf(bus.right, bus.left);
  assign curD.dy = dirOf(bus.down,  bus.up);

  axis_stepper #(.N(GRID_W)) xAxis (.pos(posX), .d(curD.dx), .wrap_en(bus.wrap_en),
                                    .next_pos(stepX), .changed(xChanged));
  axis_stepper #(.N(GRID_H)) yAxis (.pos(posY), .d(curD.dy), .wrap_en(bus.wrap_en),
                                    .next_pos(stepY), .changed(yChanged));

  assign loadX = (bus.load_x > X_MAX) ? X_MAX : bus.load_x;
  assign loadY = (bus.load_y > Y_MAX) ? Y_MAX : bus.load_y;

  always_comb begin
    nextState = curState;
    nextCnt   = cnt;
    nextLatD  = latD;
    step      = 1'b0;
    if (curD == DIR_IDLE) begin
      nextState = IDLE;
      nextCnt   = '0;
    end else begin
      case (curState)
        IDLE: begin
          step      = 1'b1;
          nextCnt   = CW'(1);
          nextState = DELAY;
        end
        DELAY, REPEAT: begin
          if (curD != latD) begin
            // A new direction mid-hold behaves like a fresh press.
            step      = 1'b1;
            nextCnt   = CW'(1);
            nextState = DELAY;
          end else if (cnt == ((curState == DELAY) ? CNT_DLY : CNT_RATE)) begin
            step      = 1'b1;
            nextCnt   = CW'(1);
            nextState = REPEAT;
          end else begin
            nextCnt   = cnt + CW'(1);
          end
        end
        default: nextState = IDLE;
      endcase
      if (step) nextLatD = curD;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      posX     <= XW'(X_INIT);
      posY     <= YW'(Y_INIT);
      movedQ   <= 1'b0;
      curState <= IDLE;
      cnt      <= '0;
      latD     <= DIR_IDLE;
    end else if (bus.load) begin
      // Load discards any step this edge and re-arms a held button as a new press.
      posX     <= loadX;
      posY     <= loadY;
      movedQ   <= (loadX != posX) || (loadY != posY);
      curState <= IDLE;
      cnt      <= '0;
      latD     <= DIR_IDLE;
    end else begin
      curState <= nextState;
      cnt      <= nextCnt;
      latD     <= nextLatD;
      movedQ   <= step && (xChanged || yChanged);
      if (step) begin
        posX <= stepX;
        posY <= stepY;
      end
    end
  end

  assign bus.userX = posX;
  assign bus.userY = posY;
  assign bus.moved = movedQ;

endmodule

// File: tb/tb_cursor_position.sv
// Directed checks of cursor_position: a default 64x32 instance driven from a vector table,
// and a 40x32 instance with slow repeat for timing, load clamp and mid-hold reset.
module tb_cursor_position;

  logic CLOCK_50 = 1'b0;
  logic rstA, rstB;
  int   checks = 0;
  int   errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  cursor_position_if #(.GRID_W(64), .GRID_H(32)) busA ();
  cursor_position_if #(.GRID_W(40), .GRID_H(32)) busB ();

  cursor_position #(.GRID_W(64), .GRID_H(32)) dutA (
    .CLOCK_50(CLOCK_50), .reset(rstA), .bus(busA));

  cursor_position #(.GRID_W(40), .GRID_H(32), .X_INIT(3), .Y_INIT(5),
                    .REPEAT_DELAY(4), .REPEAT_RATE(2)) dutB (
    .CLOCK_50(CLOCK_50), .reset(rstB), .bus(busB));

  typedef struct {
    logic       rst, l, r, u, d, wr, ld;
    logic [5:0] lx;
    logic [4:0] ly;
    logic [5:0] ex;
    logic [4:0] ey;
    logic       em;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, l, r, u, d, wr, ld, input int lx, ly, ex, ey,
                     input logic em);
    vec_t v;
    v.rst = rst; v.l = l; v.r = r; v.u = u; v.d = d; v.wr = wr; v.ld = ld;
    v.lx = 6'(lx); v.ly = 5'(ly); v.ex = 6'(ex); v.ey = 5'(ey); v.em = em;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input int gx, gy, input logic gm,
                     input int ex, ey, input logic em);
    checks++;
    if (gx != ex || gy != ey || gm !== em) begin
      errors++;
      $display("FAIL %s: got (%0d,%0d) moved=%b, want (%0d,%0d) moved=%b",
               name, gx, gy, gm, ex, ey, em);
    end
  endtask

  task automatic setB(input logic l, r, u, d, ld, input int lx, ly);
    busB.left = l; busB.right = r; busB.up = u; busB.down = d;
    busB.load = ld; busB.load_x = 6'(lx); busB.load_y = 5'(ly);
  endtask

  int expXs[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
  logic expMs[12] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    rstA = 1'b1; rstB = 1'b1;
    busA.left = 0; busA.right = 0; busA.up = 0; busA.down = 0;
    busA.wrap_en = 1; busA.load = 0; busA.load_x = 0; busA.load_y = 0;
    setB(0, 0, 0, 0, 0, 0, 0);
    busB.wrap_en = 1;

    //  rst l r u d wr ld lx ly   ex ey em
    add(1, 0,0,0,0, 1, 0, 0, 0,   0, 0, 0);   // reset
    for (int i = 1; i <= 4; i++) add(0, 0,1,0,0, 1, 0, 0, 0, i, 0, 1);
    add(0, 0,0,0,0, 1, 0, 0, 0,   4, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 0,0,0,1, 1, 0, 0, 0, 4, i, 1);
    add(0, 0,0,0,0, 1, 0, 0, 0,   4, 4, 0);
    add(0, 1,0,0,0, 1, 0, 0, 0,   3, 4, 1);   // left with wrap
    add(0, 1,0,0,0, 1, 0, 0, 0,   2, 4, 1);
    add(0, 1,0,0,0, 1, 0, 0, 0,   1, 4, 1);
    add(0, 1,0,0,0, 1, 0, 0, 0,   0, 4, 1);
    add(0, 1,0,0,0, 1, 0, 0, 0,  63, 4, 1);
    add(0, 0,0,0,0, 1, 0, 0, 0,  63, 4, 0);
    add(0, 0,0,1,0, 1, 0, 0, 0,  63, 3, 1);   // up with wrap
    add(0, 0,0,1,0, 1, 0, 0, 0,  63, 2, 1);
    add(0, 0,0,1,0, 1, 0, 0, 0,  63, 1, 1);
    add(0, 0,0,1,0, 1, 0, 0, 0,  63, 0, 1);
    add(0, 0,0,1,0, 1, 0, 0, 0,  63,31, 1);
    add(0, 0,0,1,0, 1, 0, 0, 0,  63,30, 1);
    add(0, 0,0,0,0, 1, 1, 0, 0,   0, 0, 1);   // load to origin
    for (int i = 0; i < 3; i++) add(0, 1,0,1,0, 0, 0, 0, 0, 0, 0, 0);  // clamp
    add(0, 0,1,0,1, 0, 0, 0, 0,   1, 1, 1);   // diagonal
    add(0, 0,0,0,0, 0, 0, 0, 0,   1, 1, 0);
    add(0, 1,1,0,1, 1, 0, 0, 0,   1, 2, 1);   // x cancels, y steps
    add(0, 0,0,0,0, 1, 0, 0, 0,   1, 2, 0);
    add(0, 0,0,0,0, 0, 1,63,31,  63,31, 1);
    add(0, 0,1,0,1, 0, 0, 0, 0,  63,31, 0);   // clamp at max
    add(0, 0,1,0,1, 0, 0, 0, 0,  63,31, 0);
    add(0, 0,0,0,0, 0, 1,63,31,  63,31, 0);   // load to same cell

    for (int i = 0; i < vecs.size(); i++) begin
      rstA = vecs[i].rst;
      busA.left = vecs[i].l; busA.right = vecs[i].r;
      busA.up = vecs[i].u;   busA.down = vecs[i].d;
      busA.wrap_en = vecs[i].wr; busA.load = vecs[i].ld;
      busA.load_x = vecs[i].lx;  busA.load_y = vecs[i].ly;
      tick();
      chk($sformatf("vecA[%0d]", i), busA.userX, busA.userY, busA.moved,
          vecs[i].ex, vecs[i].ey, vecs[i].em);
      rstB = 1'b0;
    end

    // Second instance: reset state with non-zero init
    rstB = 1'b1;
    tick();
    chk("B reset", busB.userX, busB.userY, busB.moved, 3, 5, 0);
    rstB = 1'b0;
    setB(0, 0, 0, 0, 1, 0, 5);
    tick();
    chk("B load origin", busB.userX, busB.userY, busB.moved, 0, 5, 1);

    // Delay 4 / rate 2: steps at E0, +4, +6, +8, +10
    setB(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("B repeat[%0d]", i), busB.userX, busB.userY, busB.moved,
          expXs[i], 5, expMs[i]);
    end
    setB(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("B release", busB.userX, busB.userY, busB.moved, 5, 5, 0);

    // Load wins over a held button and clamps x to 39
    setB(0, 1, 0, 0, 1, 50, 7);
    tick();
    chk("B load clamp", busB.userX, busB.userY, busB.moved, 39, 7, 1);
    setB(0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("B wrap after load", busB.userX, busB.userY, busB.moved, 0, 7, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("B into repeat", busB.userX, busB.userY, busB.moved, 2, 7, 1);

    // Reset mid-repeat with right still held
    rstB = 1'b1;
    tick();
    chk("B reset mid-hold", busB.userX, busB.userY, busB.moved, 3, 5, 0);
    rstB = 1'b0;
    tick();
    chk("B first step after reset", busB.userX, busB.userY, busB.moved, 4, 5, 1);
    tick();
    chk("B no step in delay", busB.userX, busB.userY, busB.moved, 4, 5, 0);
    setB(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
